// File: rtl/tt_io_pipe.sv
// Two parallel pin-to-pin delay lines with a per-path mode stage in front of the output registers,
// plus a two-word config handshake (mode, then OE mask) that flushes the pipeline before the new setup takes effect.
module tt_io_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] ui_in,
   input  logic [WIDTH-1:0] uio_in,
   output logic [WIDTH-1:0] uo_out,
   output logic [WIDTH-1:0] uio_out,
   output logic [WIDTH-1:0] uio_oe,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_data,
   output logic             cfg_ready
);

   localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_INVERT = 2'd1;
   localparam logic [1:0] MODE_SWAP   = 2'd2;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_CFG_MASK = 2'd1,
      S_FLUSH    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [1:0]       pend_q, pend_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Stages 0..DEPTH-2; the output register is the final stage.
   logic [WIDTH-1:0] a_q [0:DEPTH-2];
   logic [WIDTH-1:0] a_d [0:DEPTH-2];
   logic [WIDTH-1:0] b_q [0:DEPTH-2];
   logic [WIDTH-1:0] b_d [0:DEPTH-2];
   logic [WIDTH-1:0] uo_q, uo_d;
   logic [WIDTH-1:0] uio_q, uio_d;

   logic             xfer;
   logic             clr;
   logic [WIDTH-1:0] a_last;
   logic [WIDTH-1:0] b_last;

   assign cfg_ready = ena && (state_q == S_RUN || state_q == S_CFG_MASK);
   assign uio_oe    = cfg_ready ? mask_q : '0;
   assign xfer      = cfg_valid && cfg_ready;
   assign clr       = !ena || (state_q == S_FLUSH);
   assign uo_out    = uo_q;
   assign uio_out   = uio_q;
   assign a_last    = a_q[DEPTH-2];
   assign b_last    = b_q[DEPTH-2];

   // Config FSM; everything holds while ena is low.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pend_d  = pend_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      if (ena) begin
         case (state_q)
            S_RUN: begin
               if (xfer) begin
                  pend_d  = cfg_data[1:0];
                  state_d = S_CFG_MASK;
               end
            end
            S_CFG_MASK: begin
               if (xfer) begin
                  mask_d  = cfg_data;
                  mode_d  = pend_q;
                  cnt_d   = CW'(DEPTH - 1);
                  state_d = S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (cnt_q == '0) begin
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

   always_comb begin
      a_d[0] = clr ? '0 : ui_in;
      b_d[0] = clr ? '0 : uio_in;
      for (int i = 1; i < DEPTH - 1; i++) begin
         a_d[i] = clr ? '0 : a_q[i-1];
         b_d[i] = clr ? '0 : b_q[i-1];
      end
      uo_d  = uo_q;
      uio_d = uio_q;
      if (clr) begin
         uo_d  = '0;
         uio_d = '0;
      end else begin
         case (mode_q)
            MODE_PASS: begin
               uo_d  = a_last;
               uio_d = b_last;
            end
            MODE_INVERT: begin
               uo_d  = ~a_last;
               uio_d = ~b_last;
            end
            MODE_SWAP: begin
               uo_d  = b_last;
               uio_d = a_last;
            end
            default: begin
               uo_d  = uo_q;
               uio_d = uio_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         mode_q  <= MODE_PASS;
         pend_q  <= MODE_PASS;
         mask_q  <= '1;
         cnt_q   <= '0;
         uo_q    <= '0;
         uio_q   <= '0;
         for (int i = 0; i < DEPTH - 1; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         uo_q    <= uo_d;
         uio_q   <= uio_d;
         for (int i = 0; i < DEPTH - 1; i++) begin
            a_q[i] <= a_d[i];
            b_q[i] <= b_d[i];
         end
      end
   end

endmodule

// File: tb/tb_tt_io_pipe.sv
// Directed bench for tt_io_pipe: a DEPTH=2 instance for the main sequence and a DEPTH=4 instance
// for long-latency and reset-during-flush behaviour.
module tb_tt_io_pipe;

   logic       clk = 1'b0;
   logic       rst_n, rst4_n;
   logic       ena;
   logic [7:0] ui_in, uio_in, cfg_data;
   logic       cfg_valid, cfg_valid4;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic       cfg_ready;
   logic [7:0] uo4, uio4, oe4;
   logic       rdy4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tt_io_pipe #(.WIDTH(8), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
   );

   tt_io_pipe #(.WIDTH(8), .DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst4_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4),
      .cfg_valid(cfg_valid4), .cfg_data(cfg_data), .cfg_ready(rdy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] w);
      cfg_data  = w;
      cfg_valid = 1'b1;
      #1;
      check("cfg_ready_before_xfer", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; rst4_n = 0; ena = 0;
      ui_in = 0; uio_in = 0; cfg_data = 0; cfg_valid = 0; cfg_valid4 = 0;
      #12;
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_ena0_oe", uio_oe, 8'h00);
      check("rst_ena0_ready", cfg_ready, 0);
      ena = 1; #1;
      check("rst_oe_ff", uio_oe, 8'hFF);
      @(posedge clk); #2;
      rst_n = 1; rst4_n = 1;

      // Pass-through, latency 2
      ui_in = 8'hA5; uio_in = 8'h3C;
      tick();
      check("pass_lat1_uo", uo_out, 8'h00);
      tick();
      check("pass_uo", uo_out, 8'hA5);
      check("pass_uio", uio_out, 8'h3C);
      check("pass_oe", uio_oe, 8'hFF);

      // Invert with mask 0F
      send(8'h01);
      check("cfgmask_oe_old", uio_oe, 8'hFF);
      check("cfgmask_uo_old_mode", uo_out, 8'hA5);
      send(8'h0F);
      check("flush0_ready", cfg_ready, 0);
      check("flush0_oe", uio_oe, 8'h00);
      tick();
      check("flush1_ready", cfg_ready, 0);
      check("flush1_uo", uo_out, 8'h00);
      check("flush1_uio", uio_out, 8'h00);
      tick();
      check("postflush_ready", cfg_ready, 1);
      check("postflush_oe", uio_oe, 8'h0F);
      tick();
      check("inv_zero_uo", uo_out, 8'hFF);
      tick();
      check("inv_uo", uo_out, 8'h5A);
      check("inv_uio", uio_out, 8'hC3);

      // Swap
      ui_in = 8'h11; uio_in = 8'h22;
      send(8'h02);
      send(8'hFF);
      tick(); tick();
      check("swap_oe", uio_oe, 8'hFF);
      tick(); tick();
      check("swap_uo", uo_out, 8'h22);
      check("swap_uio", uio_out, 8'h11);

      // Freeze: output registers hold the post-flush value while inputs move
      send(8'h03);
      send(8'hFF);
      tick(); tick();
      for (int v = 1; v <= 5; v++) begin
         ui_in = 8'(v); uio_in = 8'(v + 8'h40);
         tick();
         check("freeze_uo", uo_out, 8'h00);
         check("freeze_uio", uio_out, 8'h00);
      end
      ui_in = 8'h77; uio_in = 8'h66;
      send(8'h00);
      send(8'hFF);
      tick(); tick();
      tick(); tick();
      check("restore_pass_uo", uo_out, 8'h77);
      check("restore_pass_uio", uio_out, 8'h66);

      // ena low in the middle of CFG_MASK
      send(8'h01);
      ena = 0; #1;
      check("ena0_ready", cfg_ready, 0);
      check("ena0_oe", uio_oe, 8'h00);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ena0_uo", uo_out, 8'h00);
         check("ena0_uio", uio_out, 8'h00);
         check("ena0_ready_hold", cfg_ready, 0);
      end
      ena = 1; #1;
      check("ena1_ready", cfg_ready, 1);
      check("ena1_oe_old", uio_oe, 8'hFF);
      tick();
      tick();
      check("ena1_old_mode_uo", uo_out, 8'h77);
      send(8'hF0);
      tick(); tick();
      check("mask_f0_oe", uio_oe, 8'hF0);
      check("mask_f0_ready", cfg_ready, 1);
      tick(); tick();
      check("ena_seq_inv_uo", uo_out, 8'h88);
      check("ena_seq_inv_uio", uio_out, 8'h99);

      // DEPTH=4 instance: latency and reset during FLUSH
      check("d4_pass_uo", uo4, 8'h77);
      ui_in = 8'h12;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("d4_lat_uo_old", uo4, 8'h77);
      end
      tick();
      check("d4_lat4_uo", uo4, 8'h12);
      cfg_data = 8'h01; cfg_valid4 = 1; tick();
      cfg_data = 8'h0F; tick();
      cfg_valid4 = 0;
      tick();
      check("d4_flush_ready", rdy4, 0);
      check("d4_flush_oe", oe4, 8'h00);
      rst4_n = 0; #1;
      check("d4_rst_uo", uo4, 8'h00);
      check("d4_rst_uio", uio4, 8'h00);
      check("d4_rst_oe", oe4, 8'hFF);
      #3;
      rst4_n = 1;
      tick();
      check("d4_rel_ready", rdy4, 1);
      check("d4_rel_oe", oe4, 8'hFF);
      tick(); tick(); tick();
      check("d4_rel_pass_uo", uo4, 8'h12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
